matrix_fetch_responder: RTL and testbench
=========================================

Name: matrix_fetch_responder

Overview:
Memory-side responder for the matrix multiplier's operand-fetch interface.
- Holds operand matrices A (N×P) and B (P×M) in internal register storage, loaded through a write port.
- Answers each fetch_row / fetch_col request by presenting row n of A or column m of B on mem_line.
- Drives fetch_stall and data_stall back to the multiplier, so bench and system use one consistent, latency-configurable memory model.

Parameters:
N, 2, rows of A / result rows
P, 2, inner dimension; elements per mem_line
M, 2, columns of B / result columns
DATA_WIDTH, 4, signed element width
LATENCY, 2, idle cycles between request acceptance and data presentation (≥0)
N_BIT_WIDTH, (N>1)?$clog2(N):1, row index width
M_BIT_WIDTH, (M>1)?$clog2(M):1, column index width
P_BIT_WIDTH, (P>1)?$clog2(P):1, inner index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fetch_row  in  1  request row n of A
fetch_col  in  1  request column m of B
n  in  N_BIT_WIDTH  requested row index
m  in  M_BIT_WIDTH  requested column index
stall_inject  in  1  bench/system back-pressure; holds responder busy
wr_en  in  1  storage write strobe
wr_sel  in  1  0 = A, 1 = B
wr_row  in  max(N_BIT_WIDTH,P_BIT_WIDTH)  write row index
wr_col  in  max(P_BIT_WIDTH,M_BIT_WIDTH)  write column index
wr_data  in  DATA_WIDTH  signed write data
fetch_stall  out  1  1 = cannot accept a request
data_stall  out  1  0 = mem_line valid this cycle
mem_line  out  P×DATA_WIDTH (unpacked [0:P-1])  presented row/column
rows_served  out  16  count of completed row presentations
cols_served  out  16  count of completed column presentations
err  out  1  sticky protocol error

Behaviour:
- States: IDLE, WAIT, PRESENT.
- Reset (sync, rst=1 at posedge): state=IDLE; fetch_stall=1 during the reset cycle, then follows state; data_stall=1; mem_line all 0; counters 0; err=0; storage cleared to 0.
- fetch_stall = 1 unless state==IDLE and stall_inject==0.
- data_stall = 0 only in PRESENT.
- IDLE acceptance: requests are sampled at posedge only when fetch_stall==0.
  - Exactly one of fetch_row/fetch_col high with index in range: latch kind and index.
  - Go to WAIT with counter=LATENCY, or straight to PRESENT if LATENCY==0.
- WAIT: counter decrements each cycle stall_inject==0; frozen while stall_inject==1. Counter==1 (or 0) at posedge → PRESENT.
- Result: data_stall low in the (LATENCY+1)th cycle after the accepting edge, absent stall_inject.
- PRESENT:
  - mem_line is captured on the edge entering PRESENT: A[n][0..P-1] or B[0..P-1][m].
  - Lasts exactly one cycle; stall_inject does not extend it.
  - Next edge: return to IDLE, increment rows_served or cols_served, mem_line holds its value.
- Requests are ignored when fetch_stall==1; no queuing.
- err (sticky until rst), request dropped, stay IDLE, when any of:
  - fetch_row and fetch_col both high at an accepting edge;
  - n ≥ N on a row request;
  - m ≥ M on a column request.
- Writes:
  - Accepted in any state.
  - Out-of-range indices are ignored and set err.
  - A write on the same edge that captures mem_line is not reflected in that presentation.
- Counters wrap at 2^16.
- rst mid-WAIT/PRESENT: immediate IDLE, no presentation, counters cleared.

Test Plan:
- Reset: rst=1 for 2 cycles → fetch_stall=1, data_stall=1, mem_line={0,0}, err=0, counters 0; after rst=0 → fetch_stall=0 next cycle.
- Row fetch: load A={{1,2},{3,4}}, LATENCY=2; fetch_row=1, n=1 for one accepting cycle → fetch_stall=1 immediately; data_stall=0 exactly 3 cycles later with mem_line={3,4}; rows_served=1; fetch_stall=0 the following cycle.
- Column fetch: load B={{5,6},{7,8}}; fetch_col=1, m=1 → mem_line={6,8}, cols_served=1.
- Stall inject: stall_inject=1 in IDLE with fetch_row=1 → no acceptance, data_stall stays 1. stall_inject=1 for 3 cycles mid-WAIT → presentation delayed exactly 3 cycles.
- Errors:
  - fetch_row=fetch_col=1 → err=1, no presentation, counters unchanged.
  - wr_row=2 with N=2 → err=1.
- Reset mid-WAIT: assert rst one cycle after acceptance → data_stall never drops, state IDLE, rows_served=0, storage zero (a subsequent row fetch returns {0,0}).

Source files
------------

// File: rtl/matrix_fetch_responder_if.sv
// Operand-fetch handshake between the matrix multiplier (master) and its memory responder (slave).
interface matrix_fetch_responder_if #(
  parameter int N           = 2,
  parameter int P           = 2,
  parameter int M           = 2,
  parameter int DATA_WIDTH  = 4,
  parameter int N_BIT_WIDTH = (N > 1) ? $clog2(N) : 1,
  parameter int M_BIT_WIDTH = (M > 1) ? $clog2(M) : 1
);
  logic                         fetch_row;
  logic                         fetch_col;
  logic [N_BIT_WIDTH-1:0]       n;
  logic [M_BIT_WIDTH-1:0]       m;
  logic                         fetch_stall;
  logic                         data_stall;
  logic signed [DATA_WIDTH-1:0] mem_line [0:P-1];

  modport master (
    output fetch_row, fetch_col, n, m,
    input  fetch_stall, data_stall, mem_line
  );

  modport slave (
    input  fetch_row, fetch_col, n, m,
    output fetch_stall, data_stall, mem_line
  );
endinterface

// File: rtl/matrix_fetch_responder.sv
// Memory-side responder for the matrix multiplier: stores A (N x P) and B (P x M)
// and presents one row of A or one column of B per accepted request.
//
// state   | meaning
// IDLE    | ready to accept a row/column request
// WAIT    | request latched, latency timer counting down
// PRESENT | mem_line valid for exactly one cycle
module matrix_fetch_responder #(
  parameter int N           = 2,
  parameter int P           = 2,
  parameter int M           = 2,
  parameter int DATA_WIDTH  = 4,
  parameter int LATENCY     = 2,
  parameter int N_BIT_WIDTH = (N > 1) ? $clog2(N) : 1,
  parameter int M_BIT_WIDTH = (M > 1) ? $clog2(M) : 1,
  parameter int P_BIT_WIDTH = (P > 1) ? $clog2(P) : 1,
  localparam int WR_ROW_W   = (N_BIT_WIDTH > P_BIT_WIDTH) ? N_BIT_WIDTH : P_BIT_WIDTH,
  localparam int WR_COL_W   = (P_BIT_WIDTH > M_BIT_WIDTH) ? P_BIT_WIDTH : M_BIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  matrix_fetch_responder_if.slave      bus,
  input  logic                         stall_inject,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [WR_ROW_W-1:0]          wr_row,
  input  logic [WR_COL_W-1:0]          wr_col,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic [15:0]                  rows_served,
  output logic [15:0]                  cols_served,
  output logic                         err
);
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         kind_col_q, kind_col_d;
  logic [N_BIT_WIDTH-1:0]       n_q, n_d;
  logic [M_BIT_WIDTH-1:0]       m_q, m_d;
  logic                         capture, req_err, wr_err;
  logic signed [DATA_WIDTH-1:0] mem_a [N][P];
  logic signed [DATA_WIDTH-1:0] mem_b [P][M];
  logic signed [DATA_WIDTH-1:0] cap_line [P];

  assign bus.fetch_stall = rst | (state_q != IDLE) | stall_inject;
  assign bus.data_stall  = (state_q != PRESENT);

  assign wr_err = wr_en & (wr_sel ? ((int'(wr_row) >= P) || (int'(wr_col) >= M))
                                  : ((int'(wr_row) >= N) || (int'(wr_col) >= P)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_col_d = kind_col_q;
    n_d        = n_q;
    m_d        = m_q;
    capture    = 1'b0;
    req_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stall_inject && (bus.fetch_row || bus.fetch_col)) begin
          if (bus.fetch_row && bus.fetch_col) begin
            req_err = 1'b1;
          end else if ((bus.fetch_row && int'(bus.n) >= N) ||
                       (bus.fetch_col && int'(bus.m) >= M)) begin
            req_err = 1'b1;
          end else begin
            kind_col_d = bus.fetch_col;
            n_d        = bus.n;
            m_d        = bus.m;
            if (LATENCY == 0) begin
              state_d = PRESENT;
              capture = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_W'(LATENCY);
            end
          end
        end
      end
      WAIT: begin
        // Timer is frozen, including its terminal count, while back-pressure is applied.
        if (!stall_inject) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = PRESENT;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      PRESENT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d copies of kind/index are valid for both the zero-latency and the WAIT capture paths.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      cap_line[p] = kind_col_d ? mem_b[p][m_d] : mem_a[n_d][p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kind_col_q  <= 1'b0;
      n_q         <= '0;
      m_q         <= '0;
      rows_served <= '0;
      cols_served <= '0;
      err         <= 1'b0;
      for (int p = 0; p < P; p++) bus.mem_line[p] <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < P; c++) mem_a[r][c] <= '0;
      for (int r = 0; r < P; r++)
        for (int c = 0; c < M; c++) mem_b[r][c] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_col_q <= kind_col_d;
      n_q        <= n_d;
      m_q        <= m_d;
      if (capture) begin
        for (int p = 0; p < P; p++) bus.mem_line[p] <= cap_line[p];
      end
      if (state_q == PRESENT) begin
        if (kind_col_q) cols_served <= cols_served + 16'd1;
        else            rows_served <= rows_served + 16'd1;
      end
      if (req_err || wr_err) err <= 1'b1;
      if (wr_en && !wr_err) begin
        if (wr_sel) mem_b[wr_row][wr_col] <= wr_data;
        else        mem_a[wr_row][wr_col] <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_matrix_fetch_responder.sv
// Bench for matrix_fetch_responder: directed scenarios plus random traffic,
// all checked every cycle against a request-level model of the responder.
module tb_matrix_fetch_responder;
  localparam int N   = 3;
  localparam int P   = 2;
  localparam int M   = 3;
  localparam int DW  = 4;
  localparam int LAT = 2;
  localparam int NBW = 2;
  localparam int MBW = 2;
  localparam int RW  = 2;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic stall_inject, wr_en, wr_sel;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic [15:0]   rows_served, cols_served;
  logic          err;

  always #5 clk = ~clk;

  matrix_fetch_responder_if #(.N(N), .P(P), .M(M), .DATA_WIDTH(DW)) bus ();

  matrix_fetch_responder #(.N(N), .P(P), .M(M), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_inject(stall_inject),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .rows_served(rows_served), .cols_served(cols_served), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] z(input logic [DW-1:0] v);
    return 32'(v);
  endfunction

  // Request-level model: a request is either pending (owed LAT unstalled cycles) or showing.
  logic [DW-1:0] ma [N][P];
  logic [DW-1:0] mb [P][M];
  logic [DW-1:0] eline [P];
  logic [15:0]   erows, ecols;
  bit            eerr, pending, showing, want_col, live;
  int            want_idx, clean;

  task automatic fill_line();
    for (int p = 0; p < P; p++) eline[p] = want_col ? mb[p][want_idx] : ma[want_idx][p];
  endtask

  task automatic model_step();
    if (rst) begin
      live = 1; eerr = 0; pending = 0; showing = 0; erows = 0; ecols = 0;
      for (int p = 0; p < P; p++) eline[p] = '0;
      for (int r = 0; r < N; r++) for (int c = 0; c < P; c++) ma[r][c] = '0;
      for (int r = 0; r < P; r++) for (int c = 0; c < M; c++) mb[r][c] = '0;
      return;
    end
    if (showing) begin
      showing = 0;
      if (want_col) ecols = ecols + 16'd1; else erows = erows + 16'd1;
    end else if (pending) begin
      if (!stall_inject) begin
        clean++;
        if (clean >= LAT) begin pending = 0; showing = 1; fill_line(); end
      end
    end else if (!stall_inject && (bus.fetch_row || bus.fetch_col)) begin
      if (bus.fetch_row && bus.fetch_col) eerr = 1;
      else if (bus.fetch_row && int'(bus.n) >= N) eerr = 1;
      else if (bus.fetch_col && int'(bus.m) >= M) eerr = 1;
      else begin
        want_col = bus.fetch_col;
        want_idx = bus.fetch_col ? int'(bus.m) : int'(bus.n);
        clean    = 0;
        if (LAT == 0) begin showing = 1; fill_line(); end
        else pending = 1;
      end
    end
    if (wr_en) begin
      if (wr_sel) begin
        if (int'(wr_row) < P && int'(wr_col) < M) mb[wr_row][wr_col] = wr_data;
        else eerr = 1;
      end else begin
        if (int'(wr_row) < N && int'(wr_col) < P) ma[wr_row][wr_col] = wr_data;
        else eerr = 1;
      end
    end
  endtask

  initial begin
    live = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        chk("fetch_stall", {31'b0, bus.fetch_stall},
            {31'b0, rst | pending | showing | stall_inject});
        chk("data_stall", {31'b0, bus.data_stall}, {31'b0, !showing});
        chk("err", {31'b0, err}, {31'b0, eerr});
        chk("rows_served", {16'b0, rows_served}, {16'b0, erows});
        chk("cols_served", {16'b0, cols_served}, {16'b0, ecols});
        for (int p = 0; p < P; p++) chk("mem_line", z(bus.mem_line[p]), z(eline[p]));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic quiet();
    bus.fetch_row = 0; bus.fetch_col = 0; bus.n = '0; bus.m = '0;
    stall_inject = 0; wr_en = 0; wr_sel = 0; wr_row = '0; wr_col = '0; wr_data = '0;
  endtask

  task automatic wr(input bit sel, input int r, input int c, input logic [DW-1:0] d);
    wr_en = 1; wr_sel = sel; wr_row = RW'(r); wr_col = CW'(c); wr_data = d;
    step(1);
    wr_en = 0;
  endtask

  // Issues one request, then counts cycles after the accepting edge until data_stall drops.
  task automatic fetch(input bit col, input int idx, output int lat);
    bus.fetch_row = !col; bus.fetch_col = col;
    bus.n = NBW'(idx); bus.m = MBW'(idx);
    step(1);
    chk("accept_fetch_stall", {31'b0, bus.fetch_stall}, 32'd1);
    bus.fetch_row = 0; bus.fetch_col = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (!bus.data_stall) begin lat = k; break; end
      step(1);
    end
  endtask

  initial begin
    int lat;
    quiet();
    rst = 1;
    step(1);
    chk("rst_fetch_stall", {31'b0, bus.fetch_stall}, 32'd1);
    step(1);
    chk("rst_data_stall", {31'b0, bus.data_stall}, 32'd1);
    chk("rst_line0", z(bus.mem_line[0]), 32'd0);
    chk("rst_line1", z(bus.mem_line[1]), 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rows", {16'b0, rows_served}, 32'd0);
    rst = 0;
    step(1);
    chk("post_rst_fetch_stall", {31'b0, bus.fetch_stall}, 32'd0);

    wr(0, 0, 0, 4'd1); wr(0, 0, 1, 4'd2); wr(0, 1, 0, 4'd3); wr(0, 1, 1, 4'd4);
    wr(0, 2, 0, 4'hF); wr(0, 2, 1, 4'hE);
    wr(1, 0, 0, 4'd5); wr(1, 0, 1, 4'd6); wr(1, 0, 2, 4'd3);
    wr(1, 1, 0, 4'd7); wr(1, 1, 1, 4'd8); wr(1, 1, 2, 4'd1);

    fetch(0, 1, lat);
    chk("row_latency", 32'(lat), 32'd3);
    chk("row_line0", z(bus.mem_line[0]), 32'd3);
    chk("row_line1", z(bus.mem_line[1]), 32'd4);
    step(1);
    chk("row_served", {16'b0, rows_served}, 32'd1);
    chk("row_after_fetch_stall", {31'b0, bus.fetch_stall}, 32'd0);

    fetch(1, 1, lat);
    chk("col_latency", 32'(lat), 32'd3);
    chk("col_line0", z(bus.mem_line[0]), 32'd6);
    chk("col_line1", z(bus.mem_line[1]), 32'd8);
    step(1);
    chk("col_served", {16'b0, cols_served}, 32'd1);

    stall_inject = 1; bus.fetch_row = 1; bus.n = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("inject_idle_data_stall", {31'b0, bus.data_stall}, 32'd1);
    end
    quiet();
    step(1);
    chk("inject_idle_rows", {16'b0, rows_served}, 32'd1);

    bus.fetch_row = 1; bus.n = 2'd2;
    step(1);
    bus.fetch_row = 0;
    stall_inject = 1;
    step(3);
    stall_inject = 0;
    lat = -1;
    for (int k = 4; k <= 20; k++) begin
      if (!bus.data_stall) begin lat = k; break; end
      step(1);
    end
    chk("stalled_latency", 32'(lat), 32'd6);
    chk("stalled_line0", z(bus.mem_line[0]), 32'hF);
    chk("stalled_line1", z(bus.mem_line[1]), 32'hE);
    step(1);

    bus.fetch_row = 1; bus.fetch_col = 1;
    step(1);
    quiet();
    chk("both_err", {31'b0, err}, 32'd1);
    chk("both_idle", {31'b0, bus.fetch_stall}, 32'd0);
    step(4);
    chk("both_rows", {16'b0, rows_served}, 32'd2);
    chk("both_cols", {16'b0, cols_served}, 32'd1);

    rst = 1; step(1); rst = 0;
    chk("err_cleared", {31'b0, err}, 32'd0);
    wr(1, 2, 0, 4'd5);
    chk("wr_range_err", {31'b0, err}, 32'd1);
    rst = 1; step(1); rst = 0;
    bus.fetch_col = 1; bus.m = 2'd3;
    step(1);
    quiet();
    chk("col_range_err", {31'b0, err}, 32'd1);
    step(2);

    rst = 1; step(1); rst = 0;
    wr(0, 1, 0, 4'd3); wr(0, 1, 1, 4'd4);
    bus.fetch_row = 1; bus.n = 2'd1;
    step(1);
    bus.fetch_row = 0;
    rst = 1; step(1); rst = 0;
    for (int k = 0; k < 5; k++) begin
      chk("midwait_rst_data_stall", {31'b0, bus.data_stall}, 32'd1);
      step(1);
    end
    chk("midwait_rst_rows", {16'b0, rows_served}, 32'd0);
    fetch(0, 1, lat);
    chk("midwait_rst_latency", 32'(lat), 32'd3);
    chk("midwait_rst_line0", z(bus.mem_line[0]), 32'd0);
    chk("midwait_rst_line1", z(bus.mem_line[1]), 32'd0);
    step(1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      rst          = ($urandom_range(0, 59) == 0);
      stall_inject = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 15);
      bus.fetch_row = (r <= 4) || (r == 10);
      bus.fetch_col = (r >= 5 && r <= 10);
      bus.n = ($urandom_range(0, 7) == 0) ? 2'd3 : NBW'($urandom_range(0, 2));
      bus.m = ($urandom_range(0, 7) == 0) ? 2'd3 : MBW'($urandom_range(0, 2));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_sel  = 1'($urandom_range(0, 1));
      wr_row  = ($urandom_range(0, 7) == 0) ? 2'd3 : RW'($urandom_range(0, 1));
      wr_col  = ($urandom_range(0, 7) == 0) ? 2'd3 : CW'($urandom_range(0, 1));
      wr_data = DW'($urandom);
      step(1);
    end
    quiet();
    rst = 0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
